// File: rtl/tile_loop_ctrl.sv
// Two-level row/column loop sequencer driving an inner (column) and outer (row) counter.
// Optional abort input enabled by defining TILE_LOOP_CTRL_ABORT_EN.
module tile_loop_ctrl #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clkIn,
  input  logic                 rstNIn,
`ifdef TILE_LOOP_CTRL_ABORT_EN
  input  logic                 abortIn,
`endif
  input  logic                 cmdValidIn,
  output logic                 cmdReadyOut,
  input  logic [CNT_WIDTH-1:0] cmdRowsIn,
  input  logic [CNT_WIDTH-1:0] cmdColsIn,
  output logic                 innerClrOut,
  output logic                 innerAdvOut,
  output logic [CNT_WIDTH-1:0] innerEndValOut,
  input  logic [CNT_WIDTH-1:0] innerCntIn,
  input  logic                 innerDoneIn,
  output logic                 outerClrOut,
  output logic                 outerAdvOut,
  output logic [CNT_WIDTH-1:0] outerEndValOut,
  input  logic [CNT_WIDTH-1:0] outerCntIn,
  input  logic                 outerDoneIn,
  output logic                 idxValidOut,
  input  logic                 idxReadyIn,
  output logic [CNT_WIDTH-1:0] rowOut,
  output logic [CNT_WIDTH-1:0] colOut,
  output logic                 idxLastOut,
  output logic                 doneOut
);

  typedef enum logic [2:0] {IDLE, CLR, CHECK, RUN, WRAP, FINISH} stateE;

  stateE                state;
  stateE                nextState;
  logic [CNT_WIDTH-1:0] rowsReg;
  logic [CNT_WIDTH-1:0] colsReg;
  logic                 cmdAccept;
  logic                 abortHit;
  logic                 colLast;
  logic                 rowLast;
  logic                 readyInt;
  logic                 innerClrInt;
  logic                 innerAdvInt;
  logic                 outerClrInt;
  logic                 outerAdvInt;
  logic                 validInt;
  logic                 lastInt;
  logic                 doneInt;

  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      state   <= IDLE;
      rowsReg <= '0;
      colsReg <= '0;
    end else begin
      state <= nextState;
      if (cmdAccept) begin
        rowsReg <= cmdRowsIn;
        colsReg <= cmdColsIn;
      end
    end
  end

  // Modulo arithmetic keeps cols = 2^CNT_WIDTH-1 working; zero counts never reach RUN.
  assign colLast = (innerCntIn == colsReg - CNT_WIDTH'(1));
  assign rowLast = (outerCntIn == rowsReg - CNT_WIDTH'(1));

`ifdef TILE_LOOP_CTRL_ABORT_EN
  assign abortHit = abortIn && (state != IDLE);
`else
  assign abortHit = 1'b0;
`endif

  always_comb begin
    nextState   = state;
    cmdAccept   = 1'b0;
    readyInt    = 1'b0;
    innerClrInt = 1'b0;
    innerAdvInt = 1'b0;
    outerClrInt = 1'b0;
    outerAdvInt = 1'b0;
    validInt    = 1'b0;
    lastInt     = 1'b0;
    doneInt     = 1'b0;
    unique case (state)
      IDLE: begin
        readyInt = 1'b1;
        if (cmdValidIn) begin
          cmdAccept = 1'b1;
          nextState = CLR;
        end
      end
      CLR: begin
        innerClrInt = 1'b1;
        outerClrInt = 1'b1;
        nextState   = CHECK;
      end
      CHECK: begin
        nextState = (innerDoneIn || outerDoneIn) ? FINISH : RUN;
      end
      RUN: begin
        validInt = 1'b1;
        lastInt  = colLast && rowLast;
        if (idxReadyIn) begin
          innerAdvInt = 1'b1;
          if (colLast) nextState = rowLast ? FINISH : WRAP;
        end
      end
      WRAP: begin
        innerClrInt = 1'b1;
        outerAdvInt = 1'b1;
        nextState   = RUN;
      end
      FINISH: begin
        doneInt   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // Abort wins over everything: clear both counters and suppress beats/completion.
    if (abortHit) begin
      nextState   = IDLE;
      innerClrInt = 1'b1;
      outerClrInt = 1'b1;
      innerAdvInt = 1'b0;
      outerAdvInt = 1'b0;
      validInt    = 1'b0;
      lastInt     = 1'b0;
      doneInt     = 1'b0;
    end
  end

  assign cmdReadyOut    = rstNIn && readyInt;
  assign innerClrOut    = rstNIn && innerClrInt;
  assign innerAdvOut    = rstNIn && innerAdvInt;
  assign outerClrOut    = rstNIn && outerClrInt;
  assign outerAdvOut    = rstNIn && outerAdvInt;
  assign idxValidOut    = rstNIn && validInt;
  assign idxLastOut     = rstNIn && lastInt;
  assign doneOut        = rstNIn && doneInt;
  assign innerEndValOut = rstNIn ? colsReg : '0;
  assign outerEndValOut = rstNIn ? rowsReg : '0;
  assign rowOut         = rstNIn ? outerCntIn : '0;
  assign colOut         = rstNIn ? innerCntIn : '0;

endmodule

// File: doc/tile_loop_ctrl.md
# tile_loop_ctrl

Two-level loop sequencer that generates the row/column index stream for one tile of work in the accelerator datapath. It sits directly upstream of two `counter` instances, an inner one for columns and an outer one for rows. It drives their clear, advance and end-value inputs and consumes their count and done outputs. It accepts one command (rows, cols) over a valid/ready handshake and emits rows×cols index beats with a last flag, followed by a one-cycle completion pulse.

## Interface
- `CNT_WIDTH`, 8, width of the row/col counts and of both counters.
- `clkIn`  in  1  clock; all logic on the rising edge.
- `rstNIn`  in  1  reset, synchronous and active-low.
- `cmdValidIn`  in  1  command valid.
- `cmdReadyOut`  out  1  command ready; high only in IDLE.
- `cmdRowsIn`  in  CNT_WIDTH  row count; 0 is legal.
- `cmdColsIn`  in  CNT_WIDTH  column count; 0 is legal.
- `innerClrOut` / `innerAdvOut`  out  1  inner (column) counter clear / advance.
- `innerEndValOut`  out  CNT_WIDTH  latched cols, to inner counter `endValIn`.
- `innerCntIn` / `innerDoneIn`  in  CNT_WIDTH / 1  inner counter count / done.
- `outerClrOut` / `outerAdvOut`  out  1  outer (row) counter clear / advance.
- `outerEndValOut`  out  CNT_WIDTH  latched rows, to outer counter `endValIn`.
- `outerCntIn` / `outerDoneIn`  in  CNT_WIDTH / 1  outer counter count / done.
- `idxValidOut`  out  1  index beat valid.
- `idxReadyIn`  in  1  downstream ready.
- `rowOut` / `colOut`  out  CNT_WIDTH  current indices; equal to `outerCntIn` / `innerCntIn`.
- `idxLastOut`  out  1  high on the final beat of the tile.
- `doneOut`  out  1  one-cycle completion pulse.

## Operation
- State register with states IDLE, CLR, CHECK, RUN, WRAP, FINISH. All control outputs decode combinationally from the state and the inputs.
- IDLE:
  - `cmdReadyOut`=1.
  - On `cmdValidIn`, latch rows/cols into `outerEndValOut`/`innerEndValOut` and go to CLR.
  - Latched values hold until the next accepted command.
- CLR: `innerClrOut`=`outerClrOut`=1 for exactly one cycle, then go to CHECK.
- CHECK:
  - If `innerDoneIn`|`outerDoneIn` (a zero count), go to FINISH.
  - Otherwise go to RUN.
- RUN:
  - `idxValidOut`=1.
  - `idxLastOut` = (`innerCntIn`==cols-1) & (`outerCntIn`==rows-1), computed in CNT_WIDTH modulo arithmetic. Zero counts never reach RUN.
  - On handshake (`idxValidOut`&`idxReadyIn`), `innerAdvOut`=1.
  - After the handshake on column cols-1: if it was the last beat, go to FINISH; otherwise go to WRAP.
- WRAP: `innerClrOut`=1 and `outerAdvOut`=1 for one cycle, then go to RUN.
- FINISH: `doneOut`=1 for one cycle, then go to IDLE.
- Max value: cols = 2^CNT_WIDTH-1 is legal and emits 255 columns at width 8. 2^CNT_WIDTH is not representable.
- A new command is only accepted in IDLE, so commands never overlap.

## Timing
- Reset values while `rstNIn` is low: all outputs 0, latched counts 0.
- After the first clock with `rstNIn` high, the block is in IDLE with `cmdReadyOut`=1.
- Reset asserted mid-tile: the next edge goes to IDLE with no `doneOut` pulse. The counters rely on their own reset.
- Latency from command accept to first `idxValidOut` is 3 cycles (CLR, CHECK, RUN).
- Throughput: 1 beat/cycle within a row, plus a 1-cycle WRAP bubble per row boundary.
- Tile cycle count with ready held high is rows*cols + (rows-1) + 4, counted from the accept cycle through FINISH.
- Backpressure:
  - While `idxReadyIn`=0 in RUN, the beat stays valid and stable.
  - No advance is issued.
  - `idxValidOut` never drops before its handshake.
- `doneOut` is asserted in the cycle after the final handshake.
- Zero-count tiles: `doneOut` arrives 3 cycles after accept, and `idxValidOut` never asserts.

## Configuration
- `TILE_LOOP_CTRL_ABORT_EN` defined:
  - Adds input `abortIn` (1 bit).
  - When it is high in any state other than IDLE, the next state is IDLE.
  - `innerClrOut`=`outerClrOut`=1 in that same cycle.
  - `idxValidOut` and `doneOut` are forced to 0 in that cycle.
  - `abortIn` in IDLE is ignored.
- Not defined: no `abortIn` port exists, and a tile always runs to FINISH.

## Test plan
- Reset, then rows=2, cols=3, ready=1: accept at cycle 0. Beats (0,0),(0,1),(0,2) in cycles 3-5; WRAP in cycle 6; beats (1,0),(1,1),(1,2) in cycles 7-9 with last on (1,2); `doneOut` at cycle 10.
- rows=0, cols=5: `idxValidOut` never asserts, and `doneOut` rises 3 cycles after accept. Repeat with rows=4, cols=0 for the same result.
- rows=1, cols=4 with `idxReadyIn` low 2 cycles on beat (0,1): the beat holds steady, no `innerAdvOut` is issued while stalled, and 4 beats total are delivered.
- `rstNIn` low during the beat (1,0) of a 3×3 tile: the block returns to IDLE with no `doneOut`. A following 1×1 command then emits (0,0) with last set, followed by done.
- `cmdValidIn` held high across two tiles: the second command is accepted only in the cycle after FINISH, and `cmdReadyOut` is 0 throughout the first tile.
- With `TILE_LOOP_CTRL_ABORT_EN`: abort on beat (0,2) of a 2×4 tile → IDLE next cycle, both clears pulsed, no `doneOut`.
